fetch_stage: RTL

//   Instruction fetch stage plus IF/ID pipeline register; directly feeds the control unit.
//   - Holds the PC and boots it from the reset vector word.
//   - Reads 16-bit words from instruction memory.
//   - Gathers the immediate word of two-word instructions (LDM/LDD/STD).
//   - Presents {instr, imm, pc_next, valid} to decode; obeys stall, flush and redirect.

---
 rtl/cpu_pkg.sv | 21 ++
 rtl/fetch_stage.sv | 104 ++++++++++
 2 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: opcodes, NOP encoding, fetch state encoding and the
// two-word opcode classifier used by fetch, control and hazard logic.
package cpu_pkg;

    localparam logic [4:0]  OP_LDM   = 5'b00111;
    localparam logic [4:0]  OP_LDD   = 5'b01110;
    localparam logic [4:0]  OP_STD   = 5'b01111;
    localparam logic [4:0]  OP_NOP   = 5'b11111;

    localparam logic [15:0] NOP_WORD = 16'hF800;

    localparam logic [1:0]  ST_BOOT  = 2'd0;
    localparam logic [1:0]  ST_FETCH = 2'd1;
    localparam logic [1:0]  ST_IMM   = 2'd2;

    // Opcodes whose second memory word is an immediate operand.
    function automatic logic is_two_word(input logic [4:0] op);
        return (op == OP_LDM) || (op == OP_LDD) || (op == OP_STD);
    endfunction

endpackage

// File: rtl/fetch_stage.sv
// Instruction fetch + IF/ID register: single-word instructions reach decode one cycle
// after being addressed, two-word ones after two; stall freezes PC, FSM and IF/ID.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int PC_W      = 32,
    parameter int IMEM_AW   = 20,
    parameter int RESET_VEC = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    output logic [IMEM_AW-1:0]  imem_addr,
    input  logic [15:0]         imem_rdata,
    input  logic                stall,
    input  logic                flush,
    input  logic                redirect,
    input  logic [PC_W-1:0]     redirect_pc,
    output logic [15:0]         ifid_instr,
    output logic [15:0]         ifid_imm,
    output logic [PC_W-1:0]     ifid_pc_next,
    output logic                ifid_valid
);

    logic [PC_W-1:0]    r_pc;
    logic [1:0]         r_state;
    logic [15:0]        r_instr;
    logic [15:0]        r_imm;
    logic [PC_W-1:0]    r_pc_next;
    logic               r_valid;

    logic [PC_W-1:0]    w_pc_inc;
    logic [PC_W-1:0]    w_boot_pc;
    logic               w_two_word;
    logic               w_booting;

    assign w_pc_inc   = r_pc + PC_W'(1);
    assign w_boot_pc  = PC_W'(imem_rdata);
    assign w_two_word = is_two_word(imem_rdata[15:11]);
    assign w_booting  = (r_state == ST_BOOT);

    // The boot cycle reads the vector word; afterwards the PC drives the address.
    assign imem_addr = w_booting ? IMEM_AW'(RESET_VEC) : r_pc[IMEM_AW-1:0];

    // PC and fetch FSM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc    <= '0;
            r_state <= ST_BOOT;
        end else if (w_booting) begin
            r_pc    <= w_boot_pc;
            r_state <= ST_FETCH;
        end else if (redirect) begin
            r_pc    <= redirect_pc;
            r_state <= ST_FETCH;
        end else if (flush) begin
            // A half-gathered two-word instruction is dropped; the FSM restarts.
            if (!stall) begin
                r_pc <= w_pc_inc;
            end
            r_state <= ST_FETCH;
        end else if (!stall) begin
            r_pc    <= w_pc_inc;
            r_state <= ((r_state == ST_FETCH) && w_two_word) ? ST_IMM : ST_FETCH;
        end
    end

    // IF/ID pipeline register; bubbles keep imm and pc_next from the last instruction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_instr   <= NOP_WORD;
            r_imm     <= '0;
            r_pc_next <= '0;
            r_valid   <= 1'b0;
        end else if (!w_booting) begin
            if (redirect || flush) begin
                r_instr <= NOP_WORD;
                r_valid <= 1'b0;
            end else if (!stall) begin
                case (r_state)
                    ST_FETCH: begin
                        r_instr   <= imem_rdata;
                        r_pc_next <= w_pc_inc;
                        r_valid   <= !w_two_word;
                    end
                    ST_IMM: begin
                        r_imm     <= imem_rdata;
                        r_pc_next <= w_pc_inc;
                        r_valid   <= 1'b1;
                    end
                    default: begin
                        r_instr <= NOP_WORD;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign ifid_instr   = r_instr;
    assign ifid_imm     = r_imm;
    assign ifid_pc_next = r_pc_next;
    assign ifid_valid   = r_valid;

endmodule
